// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit bus CPU: opcodes, control-word bit positions
// and a helper that builds a one-hot control word from a bit index.
package cpu_pkg;

   localparam int CW_WIDTH = 16;
   localparam int STEP_W   = 3;

   typedef logic [CW_WIDTH-1:0] ctrl_word_t;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [3:0] CW_HLT = 4'd15;
   localparam logic [3:0] CW_MI  = 4'd14;
   localparam logic [3:0] CW_RI  = 4'd13;
   localparam logic [3:0] CW_RO  = 4'd12;
   localparam logic [3:0] CW_IO  = 4'd11;
   localparam logic [3:0] CW_II  = 4'd10;
   localparam logic [3:0] CW_AI  = 4'd9;
   localparam logic [3:0] CW_AO  = 4'd8;
   localparam logic [3:0] CW_EO  = 4'd7;
   localparam logic [3:0] CW_SU  = 4'd6;
   localparam logic [3:0] CW_BI  = 4'd5;
   localparam logic [3:0] CW_OI  = 4'd4;
   localparam logic [3:0] CW_CE  = 4'd3;
   localparam logic [3:0] CW_CO  = 4'd2;
   localparam logic [3:0] CW_J   = 4'd1;
   localparam logic [3:0] CW_FI  = 4'd0;

   function automatic ctrl_word_t cw(input logic [3:0] idx);
      ctrl_word_t w;
      w      = '0;
      w[idx] = 1'b1;
      return w;
   endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath connection: instruction/flag inputs to the sequencer,
// control word and status back out to the datapath and RAM.
interface control_sequencer_if;
   import cpu_pkg::*;

   logic [3:0]        opcode;
   logic              flag_c;
   logic              flag_z;
   ctrl_word_t        ctrl;
   logic [STEP_W-1:0] step;
   logic              halted;

   modport master (
      input  opcode,
      input  flag_c,
      input  flag_z,
      output ctrl,
      output step,
      output halted
   );

   modport slave (
      output opcode,
      output flag_c,
      output flag_z,
      input  ctrl,
      input  step,
      input  halted
   );

endinterface

// File: rtl/control_sequencer_microcode.sv
// Microcode ROM: purely combinational (opcode, step, flags) -> control word.
// Every unlisted (opcode, step) pair decodes to zero.
module control_microcode
   import cpu_pkg::*;
(
   input  logic [3:0]        opcode,
   input  logic [STEP_W-1:0] step,
   input  logic              flag_c,
   input  logic              flag_z,
   output ctrl_word_t        word
);

   always_comb begin
      word = '0;
      case (step)
         3'd0: word = cw(CW_CO) | cw(CW_MI);
         3'd1: word = cw(CW_RO) | cw(CW_II) | cw(CW_CE);
         3'd2: begin
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: word = cw(CW_IO) | cw(CW_MI);
               OP_LDI: word = cw(CW_IO) | cw(CW_AI);
               OP_JMP: word = cw(CW_IO) | cw(CW_J);
               OP_JC:  word = flag_c ? (cw(CW_IO) | cw(CW_J)) : '0;
               OP_JZ:  word = flag_z ? (cw(CW_IO) | cw(CW_J)) : '0;
               OP_OUT: word = cw(CW_AO) | cw(CW_OI);
               OP_HLT: word = cw(CW_HLT);
               default: word = '0;
            endcase
         end
         3'd3: begin
            case (opcode)
               OP_LDA: word = cw(CW_RO) | cw(CW_AI);
               OP_ADD, OP_SUB: word = cw(CW_RO) | cw(CW_BI);
               OP_STA: word = cw(CW_AO) | cw(CW_RI);
               default: word = '0;
            endcase
         end
         3'd4: begin
            case (opcode)
               OP_ADD: word = cw(CW_EO) | cw(CW_AI) | cw(CW_FI);
               OP_SUB: word = cw(CW_EO) | cw(CW_AI) | cw(CW_SU) | cw(CW_FI);
               default: word = '0;
            endcase
         end
         default: word = '0;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute sequencer: microstep counter, HLT latch and control-word gating.
// A second microcode lookup on step+1 lets EARLY_END cut trailing empty steps.
module control_sequencer
   import cpu_pkg::*;
#(
   parameter int N_STEPS   = 5,
   parameter bit EARLY_END = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   control_sequencer_if.master bus
);

   logic [STEP_W-1:0] step_q;
   logic [STEP_W-1:0] step_plus;
   logic              halted_q;
   ctrl_word_t        cur_word;
   ctrl_word_t        next_word;

   assign step_plus = step_q + 3'd1;

   control_microcode u_cur (
      .opcode (bus.opcode),
      .step   (step_q),
      .flag_c (bus.flag_c),
      .flag_z (bus.flag_z),
      .word   (cur_word)
   );

   control_microcode u_next (
      .opcode (bus.opcode),
      .step   (step_plus),
      .flag_c (bus.flag_c),
      .flag_z (bus.flag_z),
      .word   (next_word)
   );

   // A HLT word freezes the counter in place; only reset releases it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_q   <= '0;
         halted_q <= 1'b0;
      end else if (!halted_q) begin
         if (cur_word[CW_HLT]) begin
            halted_q <= 1'b1;
         end else if (step_q == STEP_W'(N_STEPS - 1)) begin
            step_q <= '0;
         end else if (EARLY_END && (step_q >= 3'd2) && (next_word == '0)) begin
            step_q <= '0;
         end else begin
            step_q <= step_plus;
         end
      end
   end

   assign bus.ctrl   = (halted_q || !rst_n) ? '0 : cur_word;
   assign bus.step   = step_q;
   assign bus.halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomised scoreboard bench: two sequencers (EARLY_END off/on) driven from
// per-instruction programs and compared cycle by cycle against a reference model.
module tb_control_sequencer;

   localparam logic [15:0] B_HLT = 16'h8000, B_MI = 16'h4000, B_RI = 16'h2000, B_RO = 16'h1000;
   localparam logic [15:0] B_IO  = 16'h0800, B_II = 16'h0400, B_AI = 16'h0200, B_AO = 16'h0100;
   localparam logic [15:0] B_EO  = 16'h0080, B_SU = 16'h0040, B_BI = 16'h0020, B_OI = 16'h0010;
   localparam logic [15:0] B_CE  = 16'h0008, B_CO = 16'h0004, B_J  = 16'h0002, B_FI = 16'h0001;

   typedef struct {
      logic [3:0] op;
      logic       c;
      logic       z;
   } instr_t;

   typedef struct packed {
      logic [1:0][15:0] ctrl;
      logic [1:0][2:0]  step;
      logic [1:0]       halted;
   } exp_t;

   logic clk;
   logic rst_n;

   logic [3:0] op_drv [2];
   logic       c_drv  [2];
   logic       z_drv  [2];

   control_sequencer_if bus0 ();
   control_sequencer_if bus1 ();

   assign bus0.opcode = op_drv[0];
   assign bus0.flag_c = c_drv[0];
   assign bus0.flag_z = z_drv[0];
   assign bus1.opcode = op_drv[1];
   assign bus1.flag_c = c_drv[1];
   assign bus1.flag_z = z_drv[1];

   control_sequencer #(.N_STEPS(5), .EARLY_END(1'b0)) u_dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   control_sequencer #(.N_STEPS(5), .EARLY_END(1'b1)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   exp_t   exp_q [$];
   instr_t prog  [2][$];
   int     m_step   [2];
   bit     m_halted [2];
   bit     rand_mode;
   int     checks;
   int     passes;

   // Execute-phase words for each opcode, as listed in the instruction table.
   function automatic logic [15:0] ref_word(input logic [3:0] op, input int idx,
                                            input logic c, input logic z);
      logic [15:0] t [5];
      for (int k = 0; k < 5; k++) t[k] = 16'h0000;
      t[0] = B_CO | B_MI;
      t[1] = B_RO | B_II | B_CE;
      case (op)
         4'h1: begin t[2] = B_IO | B_MI; t[3] = B_RO | B_AI; end
         4'h2: begin t[2] = B_IO | B_MI; t[3] = B_RO | B_BI; t[4] = B_EO | B_AI | B_FI; end
         4'h3: begin t[2] = B_IO | B_MI; t[3] = B_RO | B_BI; t[4] = B_EO | B_AI | B_SU | B_FI; end
         4'h4: begin t[2] = B_IO | B_MI; t[3] = B_AO | B_RI; end
         4'h5: t[2] = B_IO | B_AI;
         4'h6: t[2] = B_IO | B_J;
         4'h7: t[2] = c ? (B_IO | B_J) : 16'h0000;
         4'h8: t[2] = z ? (B_IO | B_J) : 16'h0000;
         4'hE: t[2] = B_AO | B_OI;
         4'hF: t[2] = B_HLT;
         default: ;
      endcase
      return (idx >= 0 && idx < 5) ? t[idx] : 16'h0000;
   endfunction

   // Instruction length in cycles: always 5, or up to the last nonzero step (minimum 3).
   function automatic int instr_len(input logic [3:0] op, input logic c, input logic z,
                                    input bit early);
      int last;
      if (!early) return 5;
      last = 2;
      for (int k = 2; k < 5; k++)
         if (ref_word(op, k, c, z) != 16'h0000) last = k;
      return last + 1;
   endfunction

   task automatic apply_stimulus(input logic rst_v);
      exp_t   e;
      instr_t in;
      @(negedge clk);
      rst_n = rst_v;
      for (int d = 0; d < 2; d++) begin
         if (!rst_v) begin
            m_step[d]   = 0;
            m_halted[d] = 1'b0;
         end
         if (rst_v && !m_halted[d] && m_step[d] == 0) begin
            if (prog[d].size() > 0) begin
               in = prog[d].pop_front();
            end else if (rand_mode) begin
               in.op = 4'($urandom_range(0, 14));
               in.c  = 1'($urandom);
               in.z  = 1'($urandom);
            end else begin
               in.op = 4'h0;
               in.c  = 1'b0;
               in.z  = 1'b0;
            end
            op_drv[d] = in.op;
            c_drv[d]  = in.c;
            z_drv[d]  = in.z;
         end
         e.ctrl[d]   = (!rst_v || m_halted[d]) ? 16'h0000
                                               : ref_word(op_drv[d], m_step[d], c_drv[d], z_drv[d]);
         e.step[d]   = 3'(m_step[d]);
         e.halted[d] = m_halted[d];
         if (rst_v && !m_halted[d]) begin
            if (e.ctrl[d] == B_HLT)
               m_halted[d] = 1'b1;
            else if (m_step[d] + 1 >= instr_len(op_drv[d], c_drv[d], z_drv[d], d == 1))
               m_step[d] = 0;
            else
               m_step[d] = m_step[d] + 1;
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic check_output(input string name, input int d,
                               input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act === req) passes++;
      else $display("[TB] FAIL %s dut%0d at %0t: got %h expected %h", name, d, $time, act, req);
   endtask

   // Monitor: every cycle, compare the DUT outputs against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output("ctrl",   0, bus0.ctrl, e.ctrl[0]);
            check_output("ctrl",   1, bus1.ctrl, e.ctrl[1]);
            check_output("step",   0, {13'd0, bus0.step}, {13'd0, e.step[0]});
            check_output("step",   1, {13'd0, bus1.step}, {13'd0, e.step[1]});
            check_output("halted", 0, {15'd0, bus0.halted}, {15'd0, e.halted[0]});
            check_output("halted", 1, {15'd0, bus1.halted}, {15'd0, e.halted[1]});
         end
      end
   end

   task automatic load_both(input logic [3:0] op, input logic c, input logic z);
      instr_t in;
      in.op = op;
      in.c  = c;
      in.z  = z;
      prog[0].push_back(in);
      prog[1].push_back(in);
   endtask

   task automatic drain_programs();
      for (int i = 0; i < 300; i++) begin
         if (prog[0].size() == 0 && prog[1].size() == 0 && m_step[0] == 0 && m_step[1] == 0) break;
         apply_stimulus(1'b1);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      rand_mode = 1'b0;
      checks    = 0;
      passes    = 0;
      for (int d = 0; d < 2; d++) begin
         op_drv[d]   = 4'h0;
         c_drv[d]    = 1'b0;
         z_drv[d]    = 1'b0;
         m_step[d]   = 0;
         m_halted[d] = 1'b0;
      end

      for (int i = 0; i < 3; i++) apply_stimulus(1'b0);

      $display("[TB] directed instruction sequence");
      load_both(4'h1, 1'b0, 1'b0);
      load_both(4'h1, 1'b0, 1'b0);
      load_both(4'h2, 1'b0, 1'b0);
      load_both(4'h4, 1'b0, 1'b0);
      load_both(4'h5, 1'b0, 1'b0);
      load_both(4'h0, 1'b0, 1'b0);
      load_both(4'hE, 1'b0, 1'b0);
      load_both(4'h7, 1'b0, 1'b1);
      load_both(4'h7, 1'b1, 1'b0);
      load_both(4'h8, 1'b1, 1'b0);
      load_both(4'h8, 1'b0, 1'b1);
      load_both(4'hB, 1'b1, 1'b1);
      load_both(4'h3, 1'b0, 1'b0);
      load_both(4'h6, 1'b0, 1'b0);
      drain_programs();

      $display("[TB] reset during ADD T3");
      load_both(4'h2, 1'b0, 1'b0);
      apply_stimulus(1'b1);
      for (int i = 0; i < 10 && m_step[0] != 3; i++) apply_stimulus(1'b1);
      apply_stimulus(1'b0);
      apply_stimulus(1'b0);
      for (int i = 0; i < 6; i++) apply_stimulus(1'b1);
      drain_programs();

      $display("[TB] halt and recovery");
      load_both(4'hF, 1'b0, 1'b0);
      for (int i = 0; i < 25; i++) apply_stimulus(1'b1);
      apply_stimulus(1'b0);
      for (int i = 0; i < 6; i++) apply_stimulus(1'b1);
      drain_programs();

      $display("[TB] random opcode/flag sweep");
      rand_mode = 1'b1;
      for (int i = 0; i < 600; i++)
         apply_stimulus(($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      #4;
      checks++;
      if (exp_q.size() == 0) passes++;
      else $display("[TB] FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
